// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the memory-access controller.
package mem_ctrl_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LDR = 4'b1001;
    localparam logic [OPC_W-1:0] OP_STR = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_ctrl_fsm_timeout_ctr.sv
// Wait-cycle counter for RAM requests; flags the last allowed cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tc_c = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Sequences a single LDR/STR RAM access or an ALU writeback per instruction.
module mem_ctrl_fsm
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    state_e            state_d;
    logic [OPC_W-1:0]  op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_tc;
    logic              unused_src1;

    // Only the low ADDR_W bits of src1 form the address.
    assign unused_src1 = ^src1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs; ready beats the timeout.
    always_comb begin
        state_d = state_q;
        ram_en  = 1'b0;
        ram_rw  = 1'b0;
        addr    = ADDR_W'(pc);
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        wb_en   = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy    = 1'b0;
                ctr_clr = 1'b1;
                if (start) begin
                    state_d = is_mem_op(opcode) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                ram_en = 1'b1;
                ram_rw = (op_q == OP_STR);
                addr   = addr_q;
                ctr_en = ~ram_ready;
                if (ram_ready) begin
                    state_d = ST_DONE;
                end else if (ctr_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                wb_en   = (op_q != OP_STR);
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction latch and writeback register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            ram_wdata <= '0;
            wb_data   <= '0;
        end else if (state_q == ST_IDLE && start) begin
            op_q <= opcode;
            if (is_mem_op(opcode)) begin
                addr_q    <= src1[ADDR_W-1:0];
                ram_wdata <= src2;
            end else begin
                wb_data <= alu_result;
            end
        end else if (state_q == ST_REQ && ram_ready && op_q == OP_LDR) begin
            wb_data <= ram_rdata;
        end
    end

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clr),
        .enable(ctr_en),
        .tc_c  (ctr_tc)
    );

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed scenario bench for mem_ctrl_fsm (TIMEOUT = 4).
module tb_mem_ctrl_fsm;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PC_W   = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] alu_result;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;
    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    mem_ctrl_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PC_W   (PC_W),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .src1      (src1),
        .src2      (src2),
        .alu_result(alu_result),
        .pc        (pc),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .addr      (addr),
        .ram_wdata (ram_wdata),
        .wb_data   (wb_data),
        .wb_en     (wb_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe vector order: {ram_en, ram_rw, busy, done, err, wb_en}
    task automatic test_reset();
        rst = 1'b1; pc = 8'h05;
        step(); step();
        rst = 1'b0;
        checks++;
        if (addr !== 16'h0005) begin
            errors++; $display("FAIL reset_addr: got %h want %h", addr, 16'h0005);
        end
        checks++;
        if ({ram_en, ram_rw, busy, done, err, wb_en} !== 6'b000000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000000", {ram_en, ram_rw, busy, done, err, wb_en});
        end
        checks++;
        if (wb_data !== 32'h0 || ram_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: wb_data %h ram_wdata %h want 0 0", wb_data, ram_wdata);
        end
    endtask

    task automatic test_str();
        start = 1'b1; opcode = 4'b1010; src1 = 32'h3; src2 = 32'h21; ram_ready = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({ram_en, ram_rw, busy, done} !== 4'b1110 || addr !== 16'h0003 || ram_wdata !== 32'h21) begin
            errors++; $display("FAIL str_req: en/rw/busy/done %b addr %h wdata %h want 1110 0003 00000021",
                               {ram_en, ram_rw, busy, done}, addr, ram_wdata);
        end
        step();
        ram_ready = 1'b0;
        checks++;
        if ({done, err, wb_en} !== 3'b100 || wb_data !== 32'h0) begin
            errors++; $display("FAIL str_done: done/err/wb_en %b wb_data %h want 100 0", {done, err, wb_en}, wb_data);
        end
        step();
        checks++;
        if ({ram_en, busy, done} !== 3'b000 || ram_wdata !== 32'h21 || addr !== 16'h0005) begin
            errors++; $display("FAIL str_idle: en/busy/done %b wdata %h addr %h want 000 00000021 0005",
                               {ram_en, busy, done}, ram_wdata, addr);
        end
    endtask

    task automatic test_ldr();
        start = 1'b1; opcode = 4'b1001; src1 = 32'h0C; src2 = 32'hAA; ram_rdata = 32'h38; ram_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({ram_en, ram_rw, done} !== 3'b100 || addr !== 16'h000C || ram_wdata !== 32'hAA) begin
                errors++; $display("FAIL ldr_wait%0d: en/rw/done %b addr %h wdata %h want 100 000c 000000aa",
                                   i, {ram_en, ram_rw, done}, addr, ram_wdata);
            end
            step();
        end
        checks++;
        if (ram_en !== 1'b1 || wb_data !== 32'h0) begin
            errors++; $display("FAIL ldr_req4: en %b wb_data %h want 1 0", ram_en, wb_data);
        end
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        checks++;
        if ({done, err, wb_en} !== 3'b101 || wb_data !== 32'h38) begin
            errors++; $display("FAIL ldr_done: done/err/wb_en %b wb_data %h want 101 00000038", {done, err, wb_en}, wb_data);
        end
        step();
        checks++;
        if ({busy, done, wb_en} !== 3'b000 || wb_data !== 32'h38) begin
            errors++; $display("FAIL ldr_idle: busy/done/wb_en %b wb_data %h want 000 00000038", {busy, done, wb_en}, wb_data);
        end
    endtask

    task automatic test_alu();
        start = 1'b1; opcode = 4'b0100; alu_result = 32'h2;
        step();
        start = 1'b0;
        checks++;
        if ({ram_en, busy, done, err, wb_en} !== 5'b01101 || wb_data !== 32'h2) begin
            errors++; $display("FAIL alu_done: en/busy/done/err/wb_en %b wb_data %h want 01101 00000002",
                               {ram_en, busy, done, err, wb_en}, wb_data);
        end
        step();
        checks++;
        if ({ram_en, busy, done, wb_en} !== 4'b0000) begin
            errors++; $display("FAIL alu_idle: en/busy/done/wb_en %b want 0000", {ram_en, busy, done, wb_en});
        end
    endtask

    task automatic test_timeout();
        start = 1'b1; opcode = 4'b1001; src1 = 32'h7; ram_ready = 1'b0; ram_rdata = 32'hDEAD;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({ram_en, done, err} !== 3'b100) begin
                errors++; $display("FAIL tmo_wait%0d: en/done/err %b want 100", i, {ram_en, done, err});
            end
            step();
        end
        checks++;
        if ({ram_en, done, err, wb_en} !== 4'b0110 || wb_data !== 32'h2) begin
            errors++; $display("FAIL tmo_err: en/done/err/wb_en %b wb_data %h want 0110 00000002",
                               {ram_en, done, err, wb_en}, wb_data);
        end
        step();
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++; $display("FAIL tmo_idle: busy/done/err %b want 000", {busy, done, err});
        end
        // Ready arriving on the last allowed cycle completes normally.
        start = 1'b1; opcode = 4'b1001; src1 = 32'h8; ram_rdata = 32'h5A;
        step();
        start = 1'b0;
        step(); step(); step();
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        checks++;
        if ({done, err, wb_en} !== 3'b101 || wb_data !== 32'h5A) begin
            errors++; $display("FAIL tmo_ready_wins: done/err/wb_en %b wb_data %h want 101 0000005a", {done, err, wb_en}, wb_data);
        end
        step();
    endtask

    task automatic test_reset_mid_req();
        start = 1'b1; opcode = 4'b1001; src1 = 32'h9; src2 = 32'h77; ram_ready = 1'b0;
        step();
        opcode = 4'b0100; alu_result = 32'h99;
        step();
        start = 1'b0;
        checks++;
        if ({ram_en, ram_rw, done} !== 3'b100 || addr !== 16'h0009) begin
            errors++; $display("FAIL busy_start_ignored: en/rw/done %b addr %h want 100 0009", {ram_en, ram_rw, done}, addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ram_en, ram_rw, busy, done, err, wb_en} !== 6'b000000 || addr !== 16'h0005 ||
            wb_data !== 32'h0 || ram_wdata !== 32'h0) begin
            errors++; $display("FAIL mid_req_reset: strobes %b addr %h wb_data %h wdata %h want 000000 0005 0 0",
                               {ram_en, ram_rw, busy, done, err, wb_en}, addr, wb_data, ram_wdata);
        end
        step();
        checks++;
        if ({busy, done, wb_en} !== 3'b000 || wb_data !== 32'h0) begin
            errors++; $display("FAIL after_reset_idle: busy/done/wb_en %b wb_data %h want 000 0", {busy, done, wb_en}, wb_data);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 4'h0; src1 = '0; src2 = '0;
        alu_result = '0; pc = 8'h05; ram_rdata = '0; ram_ready = 1'b0;
        test_reset();
        test_str();
        test_ldr();
        test_alu();
        test_timeout();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_fsm.md
MEM_CTRL_FSM -- requirements
Module: mem_ctrl_fsm

Interface
REQ-001 Parameters (one per line: name, default, meaning), SHALL be:
  DATA_W, 32, data/operand width
  ADDR_W, 16, RAM address width
  PC_W, 8, program-counter width (PC_W <= ADDR_W)
  TIMEOUT, 16, maximum REQ cycles before error (>= 2)
REQ-002 Ports (one per line: name  direction  width  meaning) SHALL be:
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous reset, active-high
  start  in  1  instruction valid, sampled only in IDLE
  opcode  in  4  operation code
  src1  in  DATA_W  load/store address operand
  src2  in  DATA_W  store data operand
  alu_result  in  DATA_W  ALU result for non-memory ops
  pc  in  PC_W  fetch address
  ram_rdata  in  DATA_W  RAM read data
  ram_ready  in  1  RAM access complete
  ram_en  out  1  RAM access request
  ram_rw  out  1  1 = write, 0 = read
  addr  out  ADDR_W  RAM address bus
  ram_wdata  out  DATA_W  RAM write data
  wb_data  out  DATA_W  register-file writeback bus
  wb_en  out  1  writeback strobe
  busy  out  1  state != IDLE
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle timeout pulse

Function
REQ-003 States SHALL be IDLE, REQ, DONE, ERR.
REQ-004 Opcodes SHALL be: 4'b1001 = LDR, 4'b1010 = STR; every other value is non-memory (ALU).
REQ-005 In IDLE: addr = pc zero-extended to ADDR_W; ram_en = 0; ram_rw = 0; busy = 0.
REQ-006 IDLE with start = 1 and LDR/STR SHALL latch opcode, src1[ADDR_W-1:0] and src2, then move to REQ; the timeout counter clears.
REQ-007 IDLE with start = 1 and non-memory opcode SHALL latch alu_result into wb_data and move to DONE with no RAM access.
REQ-008 In REQ: ram_en = 1, addr = latched address, ram_rw = 1 for STR or 0 for LDR, ram_wdata = latched src2; all held stable until exit.
REQ-009 REQ with ram_ready = 1 SHALL go to DONE; for LDR, ram_rdata is registered into wb_data on that edge.
REQ-010 REQ without ram_ready SHALL increment the counter; when the counter equals TIMEOUT-1 and ram_ready = 0, go to ERR.
REQ-011 ram_ready = 1 on the timeout cycle SHALL win: go to DONE, not ERR.
REQ-012 DONE SHALL last exactly one cycle: done = 1; wb_en = 1 for LDR and ALU, 0 for STR; then IDLE.
REQ-013 ERR SHALL last one cycle: done = 1, err = 1, wb_en = 0, wb_data unchanged; then IDLE.
REQ-014 start SHALL be ignored while busy = 1; no queueing.
REQ-015 Latency SHALL be: ALU, start to done = 1 cycle; LDR/STR with immediate ready = 2 cycles; each extra REQ cycle adds 1.
REQ-016 ram_wdata outside REQ SHALL hold its last latched value; wb_data SHALL change only on REQ-007/REQ-009 updates.

Reset
REQ-017 rst = 1 at a clock edge SHALL force IDLE, clear the counter and all latched values, and zero wb_data, ram_wdata, wb_en, done, err, ram_en and ram_rw, including mid-REQ; addr then follows pc.

Structure
REQ-018 Package mem_ctrl_pkg SHALL hold the opcode constants (OP_LDR, OP_STR) and the state enum.
REQ-019 The timeout counter SHALL be the sub-module mem_timeout_ctr (clear, enable, terminal-count output); the FSM and datapath stay in mem_ctrl_fsm.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults unless stated):
  - Reset, pc = 8'h05 -> addr = 16'h0005, all strobes 0, wb_data = 0.
  - STR: src1 = 3, src2 = 32'h21, ready on first REQ cycle -> ram_en = 1, ram_rw = 1, addr = 3, ram_wdata = 32'h21; done 2 cycles after start; wb_en = 0.
  - LDR: src1 = 32'h0C, ready after 3 REQ cycles, ram_rdata = 32'h38 -> wb_data = 32'h38 with wb_en = 1 and done on the same cycle, 5 cycles after start.
  - ALU: opcode = 4'b0100, alu_result = 2 -> next cycle wb_en = 1, done = 1, wb_data = 2, ram_en never 1.
  - Timeout: TIMEOUT = 4, ready never asserted -> err = 1 and done = 1 after 4 REQ cycles, wb_en = 0; repeat with ready on the 4th REQ cycle -> done, err = 0.
  - rst asserted in the 2nd REQ cycle of an LDR, with start pulsed while busy -> next cycle IDLE, no done, the extra start is ignored.
